// File: rtl/wb_master_bridge_pkg.sv
// rtl/wb_master_bridge_pkg.sv - shared widths, FSM states and request record for the Wishbone bridge
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_master_bridge_if.sv
// rtl/wb_master_bridge_if.sv - request/response handshake plus Wishbone initiator signals
interface wb_master_bridge_if;
  import wb_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [WB_AW-1:0] req_adr_i;
  logic [WB_DW-1:0] req_dat_i;
  logic [WB_SW-1:0] req_sel_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WB_DW-1:0] rsp_dat_o;
  logic             rsp_err_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [WB_AW-1:0] wbm_adr_o;
  logic [WB_DW-1:0] wbm_dat_o;
  logic [WB_SW-1:0] wbm_sel_o;
  logic [WB_DW-1:0] wbm_dat_i;
  logic             wbm_ack_i;

  // master: the bridge itself; slave: the requester and Wishbone target around it
  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, rsp_ready_i,
           wbm_dat_i, wbm_ack_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, rsp_ready_i,
           wbm_dat_i, wbm_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - per-transaction bus-cycle counter with terminal-count flag
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_VAL = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A zero TIMEOUT never raises the flag, so the bus waits for ack forever
  assign tc = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - valid/ready to single classic Wishbone cycle initiator with ack timeout
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int ERRCNT_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  wb_master_bridge_if.master  bus,
  output logic                busy_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  state_e              state_q, state_d;
  wb_req_t             req_q, req_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic [WB_DW-1:0]    rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                tmr_clr, tmr_inc, tmr_tc;

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .tc     (tmr_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          req_d   = '{we: bus.req_we_i, adr: bus.req_adr_i,
                      dat: bus.req_dat_i, sel: bus.req_sel_i};
          we_d    = bus.req_we_i;
          cyc_d   = 1'b1;
          tmr_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        tmr_inc = 1'b1;
        // Ack is tested first so it wins over a timeout landing on the same cycle
        if (bus.wbm_ack_i) begin
          rsp_dat_d = req_q.we ? '0 : bus.wbm_dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          state_d   = RESP;
        end else if (tmr_tc) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
          end
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so it reads 0 while reset is held, whatever the state
  assign bus.req_ready_o = wb_rst_ni && (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = cyc_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_adr_o   = req_q.adr;
  assign bus.wbm_dat_o   = req_q.dat;
  assign bus.wbm_sel_o   = req_q.sel;
  assign busy_o          = (state_q != IDLE);
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - randomized self-checking bench for wb_master_bridge
module tb_wb_master_bridge;

  localparam int TO = 6;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_errs = 0;

  wb_master_bridge_if bus_if ();

  wb_master_bridge #(.TIMEOUT(TO), .ERRCNT_W(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus_if),
    .busy_o    (busy),
    .err_cnt_o (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full request/bus/response exchange. ack_at = BUS cycle on which the
  // slave acks (0 = never); hold = cycles of response backpressure.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                         input int hold, input bit pre_ready);
    bit          exp_err;
    int          exp_cyc;
    logic [31:0] exp_dat;
    int          n;
    exp_err = !(ack_at >= 1 && ack_at <= TO);
    exp_cyc = exp_err ? TO : ack_at;
    exp_dat = (we || exp_err) ? 32'h0 : rdata;

    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_req_ready", bus_if.req_ready_o, 1);
    check("idle_rsp_valid", bus_if.rsp_valid_o, 0);
    check("idle_cyc", bus_if.wbm_cyc_o, 0);
    bus_if.wbm_ack_i   = 1'b0;
    bus_if.req_valid_i = 1'b1;
    bus_if.req_we_i    = we;
    bus_if.req_adr_i   = adr;
    bus_if.req_dat_i   = dat;
    bus_if.req_sel_i   = sel;

    @(negedge clk);
    bus_if.req_valid_i = 1'b0;
    bus_if.req_adr_i   = $urandom;
    bus_if.req_dat_i   = $urandom;
    bus_if.rsp_ready_i = pre_ready;
    n = 0;
    while (bus_if.wbm_cyc_o === 1'b1 && n < TO + 4) begin
      n++;
      check("bus_stb", bus_if.wbm_stb_o, 1);
      check("bus_we", bus_if.wbm_we_o, we);
      check("bus_adr", bus_if.wbm_adr_o, adr);
      check("bus_dat", bus_if.wbm_dat_o, dat);
      check("bus_sel", bus_if.wbm_sel_o, sel);
      check("bus_req_ready", bus_if.req_ready_o, 0);
      check("bus_rsp_valid", bus_if.rsp_valid_o, 0);
      bus_if.wbm_ack_i = (n == ack_at);
      bus_if.wbm_dat_i = (n == ack_at) ? rdata : $urandom;
      @(negedge clk);
      bus_if.wbm_ack_i = 1'b0;
    end
    check("bus_cycles", n, exp_cyc);
    if (exp_err && exp_errs < 255) exp_errs++;

    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        check("hold_rsp_valid", bus_if.rsp_valid_o, 1);
        check("hold_rsp_dat", bus_if.rsp_dat_o, exp_dat);
        check("hold_rsp_err", bus_if.rsp_err_o, exp_err);
        check("hold_cyc", bus_if.wbm_cyc_o, 0);
        check("hold_req_ready", bus_if.req_ready_o, 0);
        bus_if.wbm_ack_i   = 1'($urandom_range(0, 1));
        bus_if.wbm_dat_i   = $urandom;
        bus_if.req_valid_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus_if.wbm_ack_i   = 1'b0;
      end
    end
    check("rsp_valid", bus_if.rsp_valid_o, 1);
    check("rsp_dat", bus_if.rsp_dat_o, exp_dat);
    check("rsp_err", bus_if.rsp_err_o, exp_err);
    check("rsp_err_cnt", err_cnt, exp_errs);
    check("rsp_we", bus_if.wbm_we_o, 0);
    check("rsp_cyc", bus_if.wbm_cyc_o, 0);
    bus_if.rsp_ready_i = 1'b1;
    bus_if.req_valid_i = 1'b0;

    @(negedge clk);
    bus_if.rsp_ready_i = 1'b0;
    check("post_rsp_valid", bus_if.rsp_valid_o, 0);
    check("post_busy", busy, 0);
    check("post_req_ready", bus_if.req_ready_o, 1);
    check("post_adr_hold", bus_if.wbm_adr_o, adr);
    check("post_dat_hold", bus_if.wbm_dat_o, dat);
    check("post_sel_hold", bus_if.wbm_sel_o, sel);
    check("post_err_cnt", err_cnt, exp_errs);
    // A stray ack during IDLE must leave the bridge idle
    bus_if.wbm_ack_i = 1'($urandom_range(0, 1));
    bus_if.wbm_dat_i = $urandom;
  endtask

  initial begin
    bus_if.req_valid_i = 1'b0;
    bus_if.req_we_i    = 1'b0;
    bus_if.req_adr_i   = '0;
    bus_if.req_dat_i   = '0;
    bus_if.req_sel_i   = '0;
    bus_if.rsp_ready_i = 1'b0;
    bus_if.wbm_dat_i   = '0;
    bus_if.wbm_ack_i   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cyc", bus_if.wbm_cyc_o, 0);
    check("rst_stb", bus_if.wbm_stb_o, 0);
    check("rst_we", bus_if.wbm_we_o, 0);
    check("rst_adr", bus_if.wbm_adr_o, 0);
    check("rst_dat", bus_if.wbm_dat_o, 0);
    check("rst_sel", bus_if.wbm_sel_o, 0);
    check("rst_rsp_valid", bus_if.rsp_valid_o, 0);
    check("rst_rsp_err", bus_if.rsp_err_o, 0);
    check("rst_rsp_dat", bus_if.rsp_dat_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_req_ready", bus_if.req_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", bus_if.req_ready_o, 1);

    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_AAAA, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0010, 32'h0BAD_F00D, 4'h3, 5, 32'h1234_5678, 1, 1'b0);
    run_txn(1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF, 0, 32'hFFFF_FFFF, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0030, 32'h1111_2222, 4'hC, 2, 32'hCAFE_0001, 10, 1'b0);
    run_txn(1'b0, 32'h3000_0040, 32'h0000_0001, 4'hF, TO, 32'hA5A5_A5A5, 0, 1'b1);
    run_txn(1'b1, 32'h3000_0050, 32'h7777_8888, 4'h0, 3, 32'h9999_0000, 2, 1'b0);

    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, TO + 2), $urandom, $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    for (int t = 0; t < 260; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'hF, 0, $urandom, 0, 1'b1);
    end
    check("err_cnt_saturated", err_cnt, 255);

    @(negedge clk);
    bus_if.wbm_ack_i   = 1'b0;
    bus_if.req_valid_i = 1'b1;
    bus_if.req_we_i    = 1'b1;
    bus_if.req_adr_i   = 32'h3000_0100;
    bus_if.req_dat_i   = 32'h0102_0304;
    bus_if.req_sel_i   = 4'hF;
    @(negedge clk);
    bus_if.req_valid_i = 1'b0;
    check("mid_cyc_before_rst", bus_if.wbm_cyc_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_errs = 0;
    check("mid_rst_cyc", bus_if.wbm_cyc_o, 0);
    check("mid_rst_stb", bus_if.wbm_stb_o, 0);
    check("mid_rst_rsp_valid", bus_if.rsp_valid_o, 0);
    check("mid_rst_err_cnt", err_cnt, exp_errs);
    check("mid_rst_req_ready", bus_if.req_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_req_ready", bus_if.req_ready_o, 1);
    check("mid_rel_busy", busy, 0);
    check("mid_rel_rsp_valid", bus_if.rsp_valid_o, 0);

    run_txn(1'b0, 32'h3000_0200, 32'h0, 4'h1, 1, 32'h0F0F_0F0F, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
